// File: rtl/game_pkg.sv
// Shared state encodings and parameter defaults for the game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int unsigned DEF_LIVES          = 3;
  localparam int unsigned DEF_SERVE_FRAMES   = 60;
  localparam int unsigned DEF_MISS_FRAMES    = 63;
  localparam int unsigned DEF_HITS_PER_LEVEL = 5;
  localparam int unsigned FCNT_W             = 8;
  localparam int unsigned HCNT_W             = 8;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter; clear has priority, increments saturate at 99.
module bcd_score_counter (
  input  logic       clk25,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] score
);

  always_ff @(posedge clk25) begin
    if (clear) begin
      score <= '0;
    end else if (inc && score != 8'h99) begin
      if (score[3:0] == 4'd9) begin
        score[3:0] <= '0;
        score[7:4] <= score[7:4] + 4'd1;
      end else begin
        score[3:0] <= score[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game flow sequencer: start/serve/play/miss/over, lives, BCD score and speed level.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LIVES          = DEF_LIVES,
  parameter int unsigned SERVE_FRAMES   = DEF_SERVE_FRAMES,
  parameter int unsigned MISS_FRAMES    = DEF_MISS_FRAMES,
  parameter int unsigned HITS_PER_LEVEL = DEF_HITS_PER_LEVEL
) (
  input  logic       clk25,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       hit,
  input  logic       miss,
  output logic       ball_run,
  output logic       ball_load,
  output logic       flash,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [1:0] speed,
  output logic [2:0] state
);

  localparam logic [FCNT_W-1:0] SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
  localparam logic [FCNT_W-1:0] MISS_LAST  = FCNT_W'(MISS_FRAMES - 1);
  localparam logic [HCNT_W-1:0] HIT_LAST   = HCNT_W'(HITS_PER_LEVEL - 1);

  logic              sync1, sync2, sync3;
  logic              start_evt;
  state_t            st, st_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic [HCNT_W-1:0] hcnt, hcnt_nxt;
  logic [1:0]        lives_nxt, speed_nxt;
  logic              load_nxt, score_clr, score_inc;

  assign start_evt = sync2 & ~sync3;
  assign state     = st;

  always_comb begin
    st_nxt    = st;
    fcnt_nxt  = fcnt;
    hcnt_nxt  = hcnt;
    lives_nxt = lives;
    speed_nxt = speed;
    load_nxt  = 1'b0;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (st)
      ST_IDLE, ST_OVER: begin
        if (start_evt) begin
          st_nxt    = ST_SERVE;
          lives_nxt = 2'(LIVES);
          speed_nxt = '0;
          hcnt_nxt  = '0;
          fcnt_nxt  = '0;
          score_clr = 1'b1;
          load_nxt  = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (fcnt == SERVE_LAST) begin
            st_nxt   = ST_PLAY;
            fcnt_nxt = '0;
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // miss outranks a coincident hit, which is dropped
        if (miss) begin
          st_nxt   = ST_MISS;
          fcnt_nxt = '0;
          if (lives != 2'd0) lives_nxt = lives - 2'd1;
        end else if (hit) begin
          score_inc = 1'b1;
          if (hcnt == HIT_LAST) begin
            hcnt_nxt = '0;
            if (speed != 2'd3) speed_nxt = speed + 2'd1;
          end else begin
            hcnt_nxt = hcnt + 1'b1;
          end
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (fcnt == MISS_LAST) begin
            fcnt_nxt = '0;
            if (lives == 2'd0) begin
              st_nxt = ST_OVER;
            end else begin
              st_nxt   = ST_SERVE;
              load_nxt = 1'b1;
            end
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (!Reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      st        <= ST_IDLE;
      fcnt      <= '0;
      hcnt      <= '0;
      lives     <= '0;
      speed     <= '0;
      ball_run  <= 1'b0;
      ball_load <= 1'b0;
      flash     <= 1'b0;
    end else begin
      sync1     <= start_btn;
      sync2     <= sync1;
      sync3     <= sync2;
      st        <= st_nxt;
      fcnt      <= fcnt_nxt;
      hcnt      <= hcnt_nxt;
      lives     <= lives_nxt;
      speed     <= speed_nxt;
      ball_run  <= (st_nxt == ST_PLAY);
      ball_load <= load_nxt;
      flash     <= (st_nxt == ST_MISS);
    end
  end

  // reset folded into the counter's synchronous clear
  bcd_score_counter u_score (
    .clk25 (clk25),
    .clear (score_clr | ~Reset),
    .inc   (score_inc),
    .score (score)
  );

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter LIVES, default 3: lives loaded at game start, range 1-3.
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frames the ball is held before play.
REQ-003 SHALL have parameter MISS_FRAMES, default 63: frames of miss flash.
REQ-004 SHALL have parameter HITS_PER_LEVEL, default 5: paddle hits per speed level.
REQ-005 SHALL have port clk25  in  1: 25 MHz pixel clock, the only clock.
REQ-006 SHALL have port Reset  in  1: synchronous, active-low reset.
REQ-007 SHALL have port frame_tick  in  1: one-cycle pulse at end of each frame (x=0, y=480).
REQ-008 SHALL have port start_btn  in  1: raw, asynchronous start button, active-high.
REQ-009 SHALL have port hit  in  1: one-cycle pulse on a ball-paddle bounce.
REQ-010 SHALL have port miss  in  1: one-cycle pulse when the ball touches the bottom wall.
REQ-011 SHALL have port ball_run  out  1: ball position update enable.
REQ-012 SHALL have port ball_load  out  1: one-cycle pulse that reloads the ball to the serve position.
REQ-013 SHALL have port flash  out  1: miss indication to the video path.
REQ-014 SHALL have port lives  out  2: remaining lives, binary.
REQ-015 SHALL have port score  out  8: two BCD digits, [7:4] tens and [3:0] units.
REQ-016 SHALL have port speed  out  2: ball speed level, 0-3.
REQ-017 SHALL have port state  out  3: current state encoding.

Function
REQ-018 SHALL synchronise start_btn through two flops and act only on its rising edge (start_evt), giving 3-cycle latency from pin to action.
REQ-019 SHALL implement states IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
REQ-020 IDLE/OVER: on start_evt SHALL go to SERVE, load lives=LIVES, score=0, speed=0, pulse ball_load the same cycle as the transition, and clear the frame counter.
REQ-021 SERVE: SHALL count frame_tick pulses and enter PLAY on the cycle of the SERVE_FRAMES-th tick.
REQ-022 PLAY: ball_run SHALL be 1, and SHALL be 0 in every other state.
REQ-023 PLAY: each hit SHALL increment score in BCD (units wrap 9->0 with tens carry) and saturate at 99.
REQ-024 PLAY: a hit counter SHALL increment speed every HITS_PER_LEVEL hits, saturating at 3; it SHALL keep counting after saturation without effect.
REQ-025 PLAY: miss SHALL decrement lives, clear the frame counter and enter MISS; when hit and miss coincide, miss SHALL win and the hit SHALL be discarded.
REQ-026 MISS: flash SHALL be 1; on the MISS_FRAMES-th frame_tick the block SHALL go to OVER if lives==0, else to SERVE with a ball_load pulse.
REQ-027 hit, miss and start_evt SHALL be ignored in states where they have no transition, e.g. start_evt during PLAY.
REQ-028 score and speed SHALL hold their values in OVER until the next start_evt.
REQ-029 The frame counter SHALL be at least 8 bits wide, and SERVE_FRAMES and MISS_FRAMES SHALL each be at least 1.
REQ-030 All outputs SHALL be registered; unused state codes 5-7 SHALL return to IDLE on the next cycle.

Reset
REQ-031 With Reset=0 at a clk25 edge, the block SHALL set state=IDLE, ball_run=0, ball_load=0, flash=0, lives=0, score=0, speed=0, and clear both counters and the synchroniser flops.
REQ-032 Reset asserted mid-operation in any state SHALL abort to IDLE with no ball_load pulse.

Structure
REQ-033 State encodings and parameter defaults SHALL live in a shared package, game_pkg.
REQ-034 The BCD score counter SHALL be one sub-module, bcd_score_counter: inputs clear and inc, output 8 bits, saturating at 99.

Verification
REQ-035 Reset, then start pulse: ball_load pulses once 3 cycles after the edge; lives=3; after 60 frame_ticks, state=PLAY and ball_run=1.
REQ-036 In PLAY, 12 hits: score=8'h12 and speed=2; 100 hits total: score=8'h99 and speed=3.
REQ-037 hit and miss in the same cycle with score=8'h07 and lives=3: score stays 8'h07, lives=2, state=MISS, flash=1.
REQ-038 Three misses: after the third MISS phase of 63 frames, state=OVER with flash=0; a start press gives lives=3 and score=0.
REQ-039 Reset=0 during MISS: the next cycle shows state=IDLE, flash=0, lives=0, with no ball_load pulse.
REQ-040 A start press held for 1000 cycles during PLAY causes no state change; a start glitch shorter than one clock is either ignored or taken as exactly one start_evt.
